// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Package   : fifo_pkg
//  Purpose   : Shared types and helpers for the async FIFO pointer controllers
//              (wptr_full_ctrl and its read-side sibling rptr_empty_ctrl).
//              Gray/binary conversions work on a fixed maximum width. Narrower
//              pointers are zero-extended into it and truncated on return.
//  Revision  : 1.0  initial release
// ============================================================================
package fifo_pkg;

    // Widest pointer the helpers handle (ADDR_W+1 must not exceed this)
    localparam int PTR_MAX_W      = 32;

    // Default geometry of the FIFO family
    localparam int ADDR_W_DEFAULT = 5;
    localparam int DEPTH          = 2 ** ADDR_W_DEFAULT;

    // Binary -> Gray. Zero-extended inputs stay zero-extended.
    function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Gray -> binary over the low 'width' bits; bits above 'width' return 0.
    // Each binary bit is the XOR of all Gray bits at and above it.
    function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g,
                                                      input int                   width);
        logic [PTR_MAX_W-1:0] b;
        logic                 acc;
        b   = '0;
        acc = 1'b0;
        for (int i = PTR_MAX_W - 1; i >= 0; i--) begin
            if (i < width) begin
                acc  = acc ^ g[i];
                b[i] = acc;
            end
        end
        return b;
    endfunction

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/wptr_full_ctrl.sv
`default_nettype none
// ============================================================================
//  Module    : wptr_full_ctrl
//  Purpose   : Write-domain pointer and flag controller for the async FIFO.
//              Keeps the binary/Gray write pointer and derives full,
//              almost_full, the fill level and a sticky overflow flag.
//              The read pointer comes in as an already synchronised Gray code.
//  Ports     : wclk, wrst            clock / synchronous active-high reset
//              wen                   write request
//              rptr_sync[ADDR_W:0]   synchronised Gray read pointer
//              ovf_clr               clears the sticky overflow flag
//              wr_accept             comb wen & ~full, RAM write enable
//              waddr[ADDR_W-1:0]     RAM write address
//              wbin/wptr[ADDR_W:0]   binary / Gray write pointer (registered)
//              full, almost_full     registered flags
//              wlevel[ADDR_W:0]      registered fill level 0..DEPTH
//              overflow              sticky write-while-full error
//  Revision  : 1.0  initial release
// ============================================================================
module wptr_full_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_W    = 5,
    parameter int AF_MARGIN = 4
) (
    input  logic              wclk,
    input  logic              wrst,
    input  logic              wen,
    input  logic [ADDR_W:0]   rptr_sync,
    input  logic              ovf_clr,
    output logic              wr_accept,
    output logic [ADDR_W-1:0] waddr,
    output logic [ADDR_W:0]   wbin,
    output logic [ADDR_W:0]   wptr,
    output logic              full,
    output logic              almost_full,
    output logic [ADDR_W:0]   wlevel,
    output logic              overflow
);

    localparam int            PW        = ADDR_W + 1;
    localparam int            C_DEPTH   = 2 ** ADDR_W;
    localparam logic [PW-1:0] AF_THRESH = PW'(C_DEPTH - AF_MARGIN);

    logic [PW-1:0] wbin_nxt;
    logic [PW-1:0] wptr_nxt;
    logic [PW-1:0] rbin;
    logic [PW-1:0] lvl_nxt;
    logic [PW-1:0] full_cmp;

    assign wr_accept = wen & ~full;
    assign waddr     = wbin[ADDR_W-1:0];

    // Pointer wraps modulo 2**PW without any special case
    assign wbin_nxt  = wbin + PW'(wr_accept);
    assign wptr_nxt  = PW'(bin2gray(PTR_MAX_W'(wbin_nxt)));

    // Full when the next write pointer equals the read pointer with the two
    // Gray MSBs inverted, i.e. exactly DEPTH words ahead
    assign full_cmp  = {~rptr_sync[ADDR_W:ADDR_W-1], rptr_sync[ADDR_W-2:0]};

    // Level uses the lagging synchronised read pointer, so it over-reports
    assign rbin      = PW'(gray2bin(PTR_MAX_W'(rptr_sync), PW));
    assign lvl_nxt   = wbin_nxt - rbin;

    always_ff @(posedge wclk) begin
        if (wrst) begin
            wbin        <= '0;
            wptr        <= '0;
            wlevel      <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            wbin        <= wbin_nxt;
            wptr        <= wptr_nxt;
            wlevel      <= lvl_nxt;
            full        <= (wptr_nxt == full_cmp);
            almost_full <= (lvl_nxt >= AF_THRESH);
            // Set has priority over a same-edge clear
            overflow    <= (wen & full) | (overflow & ~ovf_clr);
        end
    end

endmodule : wptr_full_ctrl
`default_nettype wire
